power_monitor_multi: RTL and testbench

- Parametrised successor to the single-comparator power sequencer.
- Enables the main power switch on `start` and scans NUM_RAILS rails through an external comparator mux, two slots per rail: undervolt, then overvolt.
- Applies separate under/over grace periods and per-slot consecutive-miss debounce; a confirmed violation latches a per-rail fault and drops the power switch.
- Sits between the top-level start control and the board power/comparator interface.

---
 rtl/power_pkg.sv | 34 +++
 rtl/power_monitor_multi_debounce.sv | 45 ++++
 rtl/power_monitor_multi.sv | 186 ++++++++++++++++++
 tb/tb_power_monitor_multi.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
`default_nettype none
// ============================================================================
// Module      : power_pkg
// Description : Shared types and constants for the multi-rail power monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package power_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Mux select idle code; the top slices it to its own select width
    localparam int                    C_SEL_W_MAX = 16;
    localparam logic [C_SEL_W_MAX-1:0] SEL_IDLE   = '1;

    // Timing defaults at a 50 MHz system clock
    localparam int C_CLK_HZ              = 50_000_000;
    localparam int C_SETTLE_DEFAULT      = 1024;    // 20.48 us per slot
    localparam int C_OVER_GRACE_DEFAULT  = 10;      // ~0.2 ms of slot-steps
    localparam int C_UNDER_GRACE_DEFAULT = 50_000;  // ~1 s of slot-steps

    // Width needed to hold the larger of the two grace reload values
    function automatic int grace_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/power_monitor_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pm_slot_debounce
// Description : Per-slot saturating consecutive-miss counter. Raises o_fault
//               combinationally on the sample that makes the count reach
//               FAULT_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module pm_slot_debounce #(
    parameter int FAULT_COUNT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_sample,
    input  logic i_counted,
    input  logic i_bad,
    output logic o_fault
);

    localparam int              CNT_W  = $clog2(FAULT_COUNT + 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(FAULT_COUNT);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FAULT_COUNT - 1);

    logic [CNT_W-1:0] r_miss;
    logic             w_hit;

    assign w_hit   = i_sample & i_counted & i_bad;
    assign o_fault = w_hit && (r_miss == C_LAST);

    // Miss counter: clear on reset/idle, bump on counted bad, clear otherwise
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_miss <= '0;
        end else if (i_sample) begin
            if (w_hit) begin
                r_miss <= (r_miss == C_MAX) ? C_MAX : r_miss + 1'b1;
            end else begin
                r_miss <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/power_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module      : power_monitor_multi
// Description : Power switch sequencer scanning NUM_RAILS rails through an
//               external comparator mux (undervolt then overvolt slot per
//               rail) with grace periods and per-slot debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module power_monitor_multi
    import power_pkg::*;
#(
    parameter int NUM_RAILS     = 3,
    parameter int SETTLE_CYCLES = C_SETTLE_DEFAULT,
    parameter int OVER_GRACE    = C_OVER_GRACE_DEFAULT,
    parameter int UNDER_GRACE   = C_UNDER_GRACE_DEFAULT,
    parameter int FAULT_COUNT   = 2,
    parameter int SEL_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_RAILS-1:0] rail_en,
    input  logic                 data,
    output logic                 kill_sw,
    output logic [SEL_W-1:0]     sel,
    output logic                 running,
    output logic                 error,
    output logic [NUM_RAILS-1:0] fault_under,
    output logic [NUM_RAILS-1:0] fault_over
);

    localparam int NSLOT = 2 * NUM_RAILS;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int GR_W  = grace_width(OVER_GRACE, UNDER_GRACE);

    localparam logic [SEL_W-1:0] C_SEL_IDLE = SEL_IDLE[SEL_W-1:0];
    localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NSLOT - 1);
    localparam logic [SET_W-1:0] C_SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GR_W-1:0]  C_OG       = GR_W'(OVER_GRACE);
    localparam logic [GR_W-1:0]  C_UG       = GR_W'(UNDER_GRACE);

    state_t               r_state,   w_state_nxt;
    logic [SET_W-1:0]     r_settle,  w_settle_nxt;
    logic [SEL_W-1:0]     r_sel,     w_sel_nxt;
    logic [GR_W-1:0]      r_og,      w_og_nxt;
    logic [GR_W-1:0]      r_ug,      w_ug_nxt;
    logic                 r_kill,    w_kill_nxt;
    logic                 r_running, w_running_nxt;
    logic                 r_error,   w_error_nxt;
    logic [NUM_RAILS-1:0] r_fu,      w_fu_nxt;
    logic [NUM_RAILS-1:0] r_fo,      w_fo_nxt;

    logic                 w_tc;
    logic                 w_clear;
    logic [NSLOT-1:0]     w_fault_vec;
    logic                 w_fault_any;

    // Sample strobe: last settle cycle of a slot while running
    assign w_tc        = (r_state == ST_RUN) && start && (r_settle == C_SET_LAST);
    assign w_clear     = !start || (r_state == ST_IDLE);
    assign w_fault_any = |w_fault_vec;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        logic w_sample;
        logic w_counted;
        logic w_bad;

        assign w_sample  = w_tc && (r_sel == SEL_W'(i));
        assign w_counted = rail_en[i/2] && (((i % 2) == 1) ? (r_og == '0) : (r_ug == '0));
        assign w_bad     = ((i % 2) == 1) ? data : !data;

        pm_slot_debounce #(
            .FAULT_COUNT (FAULT_COUNT)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .i_clear   (w_clear),
            .i_sample  (w_sample),
            .i_counted (w_counted),
            .i_bad     (w_bad),
            .o_fault   (w_fault_vec[i])
        );
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_settle_nxt  = r_settle;
        w_sel_nxt     = r_sel;
        w_og_nxt      = r_og;
        w_ug_nxt      = r_ug;
        w_kill_nxt    = r_kill;
        w_running_nxt = r_running;
        w_error_nxt   = r_error;
        w_fu_nxt      = r_fu;
        w_fo_nxt      = r_fo;
        if (!start) begin
            w_state_nxt   = ST_IDLE;
            w_settle_nxt  = '0;
            w_sel_nxt     = C_SEL_IDLE;
            w_og_nxt      = C_OG;
            w_ug_nxt      = C_UG;
            w_kill_nxt    = 1'b0;
            w_running_nxt = 1'b0;
            w_error_nxt   = 1'b0;
            w_fu_nxt      = '0;
            w_fo_nxt      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt   = ST_RUN;
                    w_kill_nxt    = 1'b1;
                    w_running_nxt = 1'b1;
                    w_sel_nxt     = '0;
                    w_settle_nxt  = '0;
                end
                ST_RUN: begin
                    if (w_tc) begin
                        w_settle_nxt = '0;
                        if (r_og != '0) w_og_nxt = r_og - 1'b1;
                        if (r_ug != '0) w_ug_nxt = r_ug - 1'b1;
                        if (w_fault_any) begin
                            w_state_nxt   = ST_FAULT;
                            w_kill_nxt    = 1'b0;
                            w_running_nxt = 1'b0;
                            w_error_nxt   = 1'b1;
                            w_sel_nxt     = C_SEL_IDLE;
                            for (int r = 0; r < NUM_RAILS; r++) begin
                                if (r_sel[SEL_W-1:1] == (SEL_W-1)'(r)) begin
                                    if (r_sel[0]) w_fo_nxt[r] = 1'b1;
                                    else          w_fu_nxt[r] = 1'b1;
                                end
                            end
                        end else begin
                            w_sel_nxt = (r_sel == C_SEL_LAST) ? '0 : r_sel + 1'b1;
                        end
                    end else begin
                        w_settle_nxt = r_settle + 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_settle  <= '0;
            r_sel     <= C_SEL_IDLE;
            r_og      <= C_OG;
            r_ug      <= C_UG;
            r_kill    <= 1'b0;
            r_running <= 1'b0;
            r_error   <= 1'b0;
            r_fu      <= '0;
            r_fo      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_settle  <= w_settle_nxt;
            r_sel     <= w_sel_nxt;
            r_og      <= w_og_nxt;
            r_ug      <= w_ug_nxt;
            r_kill    <= w_kill_nxt;
            r_running <= w_running_nxt;
            r_error   <= w_error_nxt;
            r_fu      <= w_fu_nxt;
            r_fo      <= w_fo_nxt;
        end
    end

    assign kill_sw     = r_kill;
    assign sel         = r_sel;
    assign running     = r_running;
    assign error       = r_error;
    assign fault_under = r_fu;
    assign fault_over  = r_fo;

endmodule
`default_nettype wire

// File: tb/tb_power_monitor_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_monitor_multi
// Description : Self-checking bench for power_monitor_multi with a
//               slot-level behavioural model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_monitor_multi;

    localparam int NR = 2;
    localparam int SC = 4;
    localparam int OG = 2;
    localparam int UG = 4;
    localparam int FC = 2;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          data;
    logic [NR-1:0] rail_en;
    logic          kill_sw;
    logic [SW-1:0] sel;
    logic          running;
    logic          error;
    logic [NR-1:0] fault_under;
    logic [NR-1:0] fault_over;

    always #10 clk = ~clk;

    power_monitor_multi #(
        .NUM_RAILS     (NR),
        .SETTLE_CYCLES (SC),
        .OVER_GRACE    (OG),
        .UNDER_GRACE   (UG),
        .FAULT_COUNT   (FC),
        .SEL_W         (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rail_en     (rail_en),
        .data        (data),
        .kill_sw     (kill_sw),
        .sel         (sel),
        .running     (running),
        .error       (error),
        .fault_under (fault_under),
        .fault_over  (fault_over)
    );

    int checks   = 0;
    int failures = 0;

    // Model: m_st 0=idle 1=run 2=fault
    int          m_st    = 0;
    int          m_cyc   = 0;
    int          m_sel   = 0;
    int          m_og    = OG;
    int          m_ug    = UG;
    int          m_steps = 0;
    int          m_miss [2*NR];
    logic [NR-1:0] m_fu  = '0;
    logic [NR-1:0] m_fo  = '0;
    bit          m_valid = 1'b0;
    int          mr;
    bit          mo, mc, mb;

    // Stimulus data pattern control
    int          d_mode = 0;
    logic        d_val  = 1'b0;
    logic [7:0]  pat3   = 8'b0000_1101;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the slot-level model
    task model_step();
        if (reset || !start) begin
            m_st = 0; m_cyc = 0; m_sel = 0; m_og = OG; m_ug = UG; m_steps = 0;
            m_fu = '0; m_fo = '0;
            for (int i = 0; i < 2*NR; i++) m_miss[i] = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_cyc = 0; m_sel = 0; m_steps = 0;
        end else if (m_st == 1) begin
            if (m_cyc < SC - 1) begin
                m_cyc++;
            end else begin
                m_cyc = 0;
                mr = m_sel / 2;
                mo = (m_sel % 2) == 1;
                mc = rail_en[mr] && ((mo ? m_og : m_ug) == 0);
                mb = mo ? (data === 1'b1) : (data === 1'b0);
                if (mc && mb) begin
                    if (m_miss[m_sel] < FC) m_miss[m_sel]++;
                end else begin
                    m_miss[m_sel] = 0;
                end
                if (mc && mb && m_miss[m_sel] == FC) begin
                    m_st = 2;
                    if (mo) m_fo[mr] = 1'b1;
                    else    m_fu[mr] = 1'b1;
                end else begin
                    m_sel = (m_sel + 1) % (2*NR);
                end
                if (m_og > 0) m_og--;
                if (m_ug > 0) m_ug--;
                m_steps++;
            end
        end
        m_valid = 1'b1;
    endtask

    // Advance the model on every active edge
    always @(posedge clk) model_step();

    // Compare every DUT output with the model away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_kill_sw", kill_sw, (m_st == 1) ? 1 : 0);
            chk("m_running", running, (m_st == 1) ? 1 : 0);
            chk("m_error",   error,   (m_st == 2) ? 1 : 0);
            chk("m_sel",     sel,     (m_st == 1) ? m_sel : 15);
            chk("m_fault_under", fault_under, m_fu);
            chk("m_fault_over",  fault_over,  m_fo);
        end
    end

    // Wait one cycle and set data for the slot now on the mux
    task automatic tick();
        @(negedge clk);
        case (d_mode)
            0: data = d_val;
            1: begin
                if ((m_sel % 2) == 0) data = 1'b1;
                else if (m_sel == 3)  data = ((m_steps / 4) < 8) ? pat3[m_steps / 4] : 1'b0;
                else                  data = 1'b0;
            end
            default: data = (m_sel == 0) || (m_sel == 3);
        endcase
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; data = 1'b0; rail_en = 2'b11;
        d_mode = 0; d_val = 1'b0;

        // 1: reset state, then RUN entry and sel stepping
        ticks(3);
        chk("rst_kill_sw", kill_sw, 0);
        chk("rst_sel", sel, 4'hF);
        chk("rst_error", error, 0);
        reset = 1'b0;
        tick();
        chk("run_kill_sw", kill_sw, 1);
        chk("run_running", running, 1);
        chk("run_sel", sel, 0);
        for (int s = 1; s <= 4; s++) begin
            ticks(4);
            chk("sel_step", sel, s % 4);
        end
        // 2: undervolt grace then fault on second counted visit of slot 0
        chk("ug_no_error", error, 0);
        ticks(19);
        chk("ug_pre_error", error, 0);
        tick();
        chk("ug_error", error, 1);
        chk("ug_fault_under", fault_under, 2'b01);
        chk("ug_kill_sw", kill_sw, 0);
        chk("ug_sel", sel, 4'hF);
        ticks(3);
        chk("fault_hold", fault_under, 2'b01);

        // 5: restart from FAULT, overvolt grace reloaded
        start = 1'b0;
        tick();
        chk("idle_fault_under", fault_under, 0);
        chk("idle_error", error, 0);
        start = 1'b1; d_val = 1'b1;
        tick();
        chk("rerun_sel", sel, 0);
        ticks(8);
        chk("og_grace_error", error, 0);
        ticks(23);
        chk("og_pre_error", error, 0);
        tick();
        chk("og_fault_over", fault_over, 2'b10);
        chk("og_fault_under", fault_under, 2'b00);

        // 3: good sample between bad visits clears the miss count
        start = 1'b0;
        tick();
        start = 1'b1; d_mode = 1;
        tick();
        ticks(63);
        chk("deb_pre_error", error, 0);
        tick();
        chk("deb_fault_over", fault_over, 2'b10);
        chk("deb_error", error, 1);

        // 4: disabled rail never faults
        start = 1'b0;
        tick();
        rail_en = 2'b01; d_mode = 2; start = 1'b1;
        tick();
        ticks(84);
        chk("dis_error", error, 0);
        chk("dis_running", running, 1);

        // 6: reset mid-slot at settle count 2
        start = 1'b0;
        tick();
        start = 1'b1;
        ticks(3);
        reset = 1'b1;
        tick();
        chk("mid_rst_kill_sw", kill_sw, 0);
        chk("mid_rst_sel", sel, 4'hF);
        chk("mid_rst_running", running, 0);
        reset = 1'b0;
        tick();
        chk("mid_rerun_running", running, 1);
        chk("mid_rerun_sel", sel, 0);
        ticks(3);
        chk("mid_settle_sel", sel, 0);
        tick();
        chk("mid_first_step", sel, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
